uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Second-generation UART receiver: oversampled serial-to-parallel conversion with run-time frame format (5–9 data bits, optional even/odd parity, 1 or 2 stop bits), 3-sample majority voting, input synchronisation, and a held output register with valid/ack handshake and overrun detection. It replaces the fixed-format receiver at the serial pin side of the UART subsystem and feeds parallel words plus per-frame error flags to the system-side logic.

## Interface
- DATA_W, 8: maximum data bits per frame (5..9); width of P_DATA.
- PRESCALE_W, 6: width of PRESCALE (oversampling ratio up to 2^PRESCALE_W-1).
- CLK  in  1  oversampling clock; the only clock.
- RST  in  1  reset; synchronous, active-high.
- RX_IN  in  1  asynchronous serial input, idle high.
- PRESCALE  in  PRESCALE_W  CLK cycles per bit; legal 4..2^PRESCALE_W-1.
- DATA_LEN  in  4  data bits per frame; legal 5..DATA_W.
- PAR_EN  in  1  1 = parity bit present.
- PAR_TYP  in  1  0 = even, 1 = odd.
- STOP2  in  1  1 = two stop bits checked.
- DATA_ACK  in  1  consumer accepts current word.
- P_DATA  out  DATA_W  received word, LSB = first data bit, right-justified, unused upper bits 0.
- DATA_VALID  out  1  P_DATA and flags hold an unconsumed frame.
- PAR_ERR  out  1  parity mismatch for held frame.
- STP_ERR  out  1  any checked stop bit sampled 0 for held frame.
- BRK_DET  out  1  held frame was a break (all data, parity, stop samples 0).
- OVR_ERR  out  1  one-cycle pulse: a frame was dropped.

## Operation
- RX_IN passes a 2-flop synchroniser (reset value 1); all logic uses the synchronised signal rx_s.
- PRESCALE, DATA_LEN, PAR_EN, PAR_TYP, STOP2 are latched on IDLE->START; changes mid-frame have no effect.
- Edge counter 0..PRESCALE-1 per bit, cleared on state entry and on wrap; bit counter counts bits within DATA/STOP.
- Per bit: mid = PRESCALE>>1; rx_s sampled at edges mid-1, mid, mid+1; bit value = majority of three, decided at edge mid+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s = 0 -> START.
  - START: at decision, bit = 1 -> IDLE (glitch, nothing reported); bit = 0 -> continue to DATA at end of bit period.
  - DATA: DATA_LEN bits shifted LSB-first; after last -> PARITY if PAR_EN else STOP.
  - PARITY: expected = XOR(data bits) ^ PAR_TYP; mismatch sets PAR_ERR.
  - STOP: one or two (STOP2) bits; any 0 sets STP_ERR. At the decision of the last stop bit the frame completes and the FSM goes to IDLE the next cycle (no wait for end of stop bit).
- Frame completion, DATA_VALID = 0 or DATA_ACK = 1 in that cycle: P_DATA, PAR_ERR, STP_ERR, BRK_DET loaded; DATA_VALID = 1. Error frames are delivered, not dropped.
- Frame completion with DATA_VALID = 1 and DATA_ACK = 0: new frame discarded, held word/flags unchanged, OVR_ERR = 1 for one cycle.
- DATA_ACK with DATA_VALID = 1 and no completion: DATA_VALID = 0 next cycle; P_DATA/flags keep last value. DATA_ACK while DATA_VALID = 0 is ignored.
- Reset (any state, mid-frame included): FSM IDLE, counters 0, synchroniser 1, P_DATA 0, DATA_VALID/PAR_ERR/STP_ERR/BRK_DET/OVR_ERR 0.

## Timing
- Cycle 0 = first cycle in START; RX_IN falling edge to cycle 0 = 3 cycles (2 sync + IDLE detect).
- Bit k (start = 0) occupies cycles k·P .. k·P+P-1; decision at k·P+mid+1.
- Last stop index L = 1 + DATA_LEN + PAR_EN + STOP2; DATA_VALID and outputs change at cycle L·P+mid+2 (registered).
- Back-to-back frames: new start bit detected from the cycle after completion; tolerates a following start edge from half a stop bit onward.
- OVR_ERR asserted in the same cycle DATA_VALID would have been (re)loaded.

## Test plan
- P=8, LEN=8, PAR_EN=1 even, 1 stop, send 0xA5 -> DATA_VALID at cycle 86, P_DATA=0x0A5, all flags 0; holds until DATA_ACK, drops next cycle.
- P=16, LEN=5, odd parity, STOP2=1, send 0x13 with wrong parity bit and second stop = 0 -> P_DATA=0x013, PAR_ERR=1, STP_ERR=1.
- 3-cycle low pulse on RX_IN at P=8 -> no DATA_VALID, FSM back in IDLE; a single flipped sample at edge mid of each data bit of 0x3C -> P_DATA=0x3C.
- RX_IN held low 12 bit periods, LEN=8, parity on -> P_DATA=0, PAR_ERR=0, STP_ERR=1, BRK_DET=1.
- Two frames 0x11, 0x22 without ACK -> P_DATA stays 0x11, OVR_ERR one-cycle pulse; repeat with DATA_ACK on completion cycle -> P_DATA=0x22, DATA_VALID stays 1, no OVR_ERR.
- RST asserted mid-DATA, then frame 0x5A -> all outputs 0 after reset cycle, then 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with run-time frame format,
// majority-vote sampling, held output word and overrun reporting.
module uart_rx_cfg #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic [3:0]            DATA_LEN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic                  DATA_ACK,
  output logic [DATA_W-1:0]     P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  BRK_DET,
  output logic                  OVR_ERR
);

  localparam logic [PRESCALE_W-1:0] PW1 = PRESCALE_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t r_state, w_next;

  logic [1:0]            r_sync;
  logic [PRESCALE_W-1:0] r_pre, r_edge;
  logic [3:0]            r_len, r_bit;
  logic                  r_pen, r_ptyp, r_stop2;
  logic [1:0]            r_smp;
  logic [DATA_W-1:0]     r_shift;
  logic                  r_pbit, r_serr, r_any1;

  logic                  w_rx, w_dec, w_wrap, w_maj;
  logic                  w_last_stop, w_done;
  logic [PRESCALE_W-1:0] w_mid;

  assign w_rx   = r_sync[1];
  assign w_mid  = r_pre >> 1;
  assign w_dec  = (r_edge == w_mid + PW1);
  assign w_wrap = (r_edge == r_pre - PW1);
  assign w_maj  = (r_smp[0] & r_smp[1]) |
                  (r_smp[0] & w_rx) |
                  (r_smp[1] & w_rx);
  assign w_last_stop = (r_bit == {3'b000, r_stop2});
  assign w_done = (r_state == S_STOP) && w_dec &&
                  w_last_stop;

  // Two-flop synchroniser for the asynchronous serial pin.
  always_ff @(posedge CLK) begin
    if (RST) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], RX_IN};
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; decisions happen at the third vote sample.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (!w_rx) w_next = S_START;
      S_START:
        if (w_dec && w_maj)  w_next = S_IDLE;
        else if (w_wrap)     w_next = S_DATA;
      S_DATA:
        if (w_wrap && r_bit == r_len - 4'd1)
          w_next = r_pen ? S_PARITY : S_STOP;
      S_PARITY:
        if (w_wrap) w_next = S_STOP;
      S_STOP:
        if (w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Frame format is frozen when a start edge is seen.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pre   <= '0;
      r_len   <= '0;
      r_pen   <= 1'b0;
      r_ptyp  <= 1'b0;
      r_stop2 <= 1'b0;
    end else if (r_state == S_IDLE && !w_rx) begin
      r_pre   <= PRESCALE;
      r_len   <= DATA_LEN;
      r_pen   <= PAR_EN;
      r_ptyp  <= PAR_TYP;
      r_stop2 <= STOP2;
    end
  end

  // Edge and bit counters; both restart on every state change.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_edge <= '0;
      r_bit  <= '0;
    end else if (r_state == S_IDLE || w_next != r_state) begin
      r_edge <= '0;
      r_bit  <= '0;
    end else if (w_wrap) begin
      r_edge <= '0;
      r_bit  <= r_bit + 4'd1;
    end else begin
      r_edge <= r_edge + PW1;
    end
  end

  // Vote samples and per-frame accumulation of data and status.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_smp   <= '0;
      r_shift <= '0;
      r_pbit  <= 1'b0;
      r_serr  <= 1'b0;
      r_any1  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_shift <= '0;
      r_pbit  <= 1'b0;
      r_serr  <= 1'b0;
      r_any1  <= 1'b0;
    end else begin
      if (r_edge == w_mid - PW1) r_smp[0] <= w_rx;
      if (r_edge == w_mid)       r_smp[1] <= w_rx;
      if (w_dec && r_state != S_START) begin
        r_any1 <= r_any1 | w_maj;
        if (r_state == S_DATA) begin
          for (int i = 0; i < DATA_W; i++)
            if (r_bit == 4'(i)) r_shift[i] <= w_maj;
        end
        if (r_state == S_PARITY) r_pbit <= w_maj;
        if (r_state == S_STOP && !w_maj) r_serr <= 1'b1;
      end
    end
  end

  // Held output word with valid/ack handshake and overrun pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      BRK_DET    <= 1'b0;
      OVR_ERR    <= 1'b0;
    end else begin
      OVR_ERR <= 1'b0;
      if (w_done) begin
        if (!DATA_VALID || DATA_ACK) begin
          P_DATA     <= r_shift;
          DATA_VALID <= 1'b1;
          PAR_ERR    <= r_pen &
                        (r_pbit ^ (^r_shift) ^ r_ptyp);
          STP_ERR    <= r_serr | ~w_maj;
          BRK_DET    <= ~(r_any1 | w_maj);
        end else begin
          OVR_ERR <= 1'b1;
        end
      end else if (DATA_ACK) begin
        DATA_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: table-driven frames plus hand sequences for glitch,
// break, overrun, ack-on-completion and mid-frame reset.
module tb_uart_rx_cfg;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic [3:0] DATA_LEN;
  logic       PAR_EN, PAR_TYP, STOP2, DATA_ACK;
  logic [8:0] P_DATA;
  logic       DATA_VALID, PAR_ERR, STP_ERR, BRK_DET, OVR_ERR;

  uart_rx_cfg #(.DATA_W(9), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN),
    .PRESCALE(PRESCALE), .DATA_LEN(DATA_LEN),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .DATA_ACK(DATA_ACK), .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR),
    .STP_ERR(STP_ERR), .BRK_DET(BRK_DET),
    .OVR_ERR(OVR_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int pre; int len; bit pen; bit ptyp; bit st2;
    logic [8:0] d; bit badp; bit st1v; bit st2v;
    logic [8:0] xd; bit xp; bit xs; bit xb;
  } vec_t;

  typedef struct {
    logic [8:0] d; bit p; bit s; bit b;
  } exp_t;

  vec_t tv[7];
  exp_t sb[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, s0 = 0, rise_cyc = 0;
  int n_rise = 0, n_ovr = 0, n_vlow = 0;
  logic pv = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (DATA_VALID === 1'b1 && pv !== 1'b1) begin
      rise_cyc = cyc;
      n_rise++;
    end
    if (OVR_ERR === 1'b1) n_ovr++;
    if (DATA_VALID !== 1'b1) n_vlow++;
    pv = DATA_VALID;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic mk(input int len, input logic [8:0] d,
                    input bit pen, input bit ptyp,
                    input bit badp, input bit st1v,
                    input bit st2, input bit st2v,
                    output logic [15:0] bits,
                    output int nb);
    logic p;
    bits = 16'hffff;
    bits[0] = 1'b0;
    p = ptyp;
    for (int i = 0; i < len; i++) begin
      bits[1+i] = d[i];
      p ^= d[i];
    end
    nb = 1 + len;
    if (pen) begin
      bits[nb] = p ^ badp;
      nb++;
    end
    bits[nb] = st1v;
    nb++;
    if (st2) begin
      bits[nb] = st2v;
      nb++;
    end
  endtask

  task automatic drive(input int pre, input int nb,
                       input logic [15:0] bits,
                       input int flo, input int fhi,
                       input int ack_j, input int tail);
    int mid, k;
    logic v;
    mid = pre / 2;
    for (int j = 0; j < nb * pre + tail; j++) begin
      @(negedge CLK);
      if (j == 0) s0 = cyc;
      k = j / pre;
      v = (j < nb * pre) ? bits[k] : 1'b1;
      if (j < nb * pre && k >= flo && k <= fhi &&
          (j % pre) == mid + 1)
        v = ~v;
      RX_IN = v;
      DATA_ACK = (j == ack_j);
    end
    @(negedge CLK);
    RX_IN = 1'b1;
    DATA_ACK = 1'b0;
  endtask

  task automatic cfg(input int pre, input int len,
                     input bit pen, input bit ptyp,
                     input bit st2);
    PRESCALE = 6'(pre);
    DATA_LEN = 4'(len);
    PAR_EN = pen;
    PAR_TYP = ptyp;
    STOP2 = st2;
  endtask

  task automatic push(input logic [8:0] d, input bit p,
                      input bit s, input bit b);
    exp_t e;
    e.d = d; e.p = p; e.s = s; e.b = b;
    sb.push_back(e);
  endtask

  task automatic check_frame(input string nm,
                             input int xr);
    exp_t e;
    int w;
    w = 0;
    while (DATA_VALID !== 1'b1 && w < 400) begin
      @(negedge CLK);
      w++;
    end
    chk({nm, " valid"}, 32'(DATA_VALID), 1);
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, " data"}, 32'(P_DATA), 32'(e.d));
      chk({nm, " par"}, 32'(PAR_ERR), 32'(e.p));
      chk({nm, " stp"}, 32'(STP_ERR), 32'(e.s));
      chk({nm, " brk"}, 32'(BRK_DET), 32'(e.b));
      if (xr >= 0)
        chk({nm, " cycle"}, rise_cyc, xr);
    end
  endtask

  task automatic ack_chk(input string nm,
                         input logic [8:0] xd);
    @(negedge CLK);
    DATA_ACK = 1'b1;
    @(negedge CLK);
    DATA_ACK = 1'b0;
    chk({nm, " drop"}, 32'(DATA_VALID), 0);
    chk({nm, " hold"}, 32'(P_DATA), 32'(xd));
  endtask

  task automatic out_zero(input string nm);
    chk({nm, " pdata"}, 32'(P_DATA), 0);
    chk({nm, " valid"}, 32'(DATA_VALID), 0);
    chk({nm, " par"}, 32'(PAR_ERR), 0);
    chk({nm, " stp"}, 32'(STP_ERR), 0);
    chk({nm, " brk"}, 32'(BRK_DET), 0);
    chk({nm, " ovr"}, 32'(OVR_ERR), 0);
  endtask

  initial begin
    logic [15:0] bits;
    int nb, r0, o0, v0;

    tv[0] = '{8, 8, 1, 0, 0, 9'h0A5, 0, 1, 1,
              9'h0A5, 0, 0, 0};
    tv[1] = '{16, 5, 1, 1, 1, 9'h013, 1, 1, 0,
              9'h013, 1, 1, 0};
    tv[2] = '{4, 9, 0, 0, 0, 9'h1AB, 0, 1, 1,
              9'h1AB, 0, 0, 0};
    tv[3] = '{63, 7, 1, 1, 0, 9'h055, 0, 1, 1,
              9'h055, 0, 0, 0};
    tv[4] = '{5, 6, 1, 0, 1, 9'h02A, 0, 1, 1,
              9'h02A, 0, 0, 0};
    tv[5] = '{12, 8, 0, 0, 0, 9'h000, 0, 0, 1,
              9'h000, 0, 1, 1};
    tv[6] = '{8, 8, 1, 1, 0, 9'h000, 0, 1, 1,
              9'h000, 0, 0, 0};

    RST = 1'b1;
    RX_IN = 1'b1;
    DATA_ACK = 1'b0;
    cfg(8, 8, 0, 0, 0);
    repeat (3) @(negedge CLK);
    out_zero("reset");
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    for (int i = 0; i < 7; i++) begin
      cfg(tv[i].pre, tv[i].len, tv[i].pen,
          tv[i].ptyp, tv[i].st2);
      mk(tv[i].len, tv[i].d, tv[i].pen, tv[i].ptyp,
         tv[i].badp, tv[i].st1v, tv[i].st2,
         tv[i].st2v, bits, nb);
      push(tv[i].xd, tv[i].xp, tv[i].xs, tv[i].xb);
      drive(tv[i].pre, nb, bits, 1, 0, -1,
            tv[i].pre + 6);
      check_frame($sformatf("vec%0d", i),
                  s0 + (nb - 1) * tv[i].pre +
                  tv[i].pre / 2 + 5);
      ack_chk($sformatf("vec%0d", i), tv[i].xd);
    end

    // Short low pulse must be rejected.
    cfg(8, 8, 0, 0, 0);
    r0 = n_rise;
    @(negedge CLK);
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (40) @(negedge CLK);
    chk("glitch rise", n_rise - r0, 0);
    chk("glitch valid", 32'(DATA_VALID), 0);

    // One flipped vote sample per data bit.
    mk(8, 9'h03C, 0, 0, 0, 1, 0, 1, bits, nb);
    push(9'h03C, 0, 0, 0);
    drive(8, nb, bits, 1, 8, -1, 14);
    check_frame("flip", s0 + 9 * 8 + 4 + 5);
    ack_chk("flip", 9'h03C);

    // Break: line low for 12 bit periods.
    cfg(8, 8, 1, 0, 0);
    push(9'h000, 0, 1, 1);
    drive(8, 12, 16'h0000, 1, 0, -1, 14);
    check_frame("break", s0 + 10 * 8 + 4 + 5);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // Overrun, then ack in the completion cycle.
    cfg(8, 8, 0, 0, 0);
    mk(8, 9'h011, 0, 0, 0, 1, 0, 1, bits, nb);
    push(9'h011, 0, 0, 0);
    drive(8, nb, bits, 1, 0, -1, 14);
    check_frame("ovr1", s0 + 9 * 8 + 4 + 5);
    o0 = n_ovr;
    mk(8, 9'h022, 0, 0, 0, 1, 0, 1, bits, nb);
    drive(8, nb, bits, 1, 0, -1, 14);
    chk("ovr pulse", n_ovr - o0, 1);
    chk("ovr held", 32'(P_DATA), 32'h011);
    chk("ovr valid", 32'(DATA_VALID), 1);
    o0 = n_ovr;
    v0 = n_vlow;
    push(9'h022, 0, 0, 0);
    drive(8, nb, bits, 1, 0, 3 + 9 * 8 + 4 + 1, 14);
    chk("ackc ovr", n_ovr - o0, 0);
    chk("ackc stay", n_vlow - v0, 0);
    check_frame("ackc", -1);

    // Reset in the middle of the data bits.
    mk(8, 9'h05A, 0, 0, 0, 1, 0, 1, bits, nb);
    drive(8, 5, bits, 1, 0, -1, 0);
    RST = 1'b1;
    @(negedge CLK);
    out_zero("midrst");
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    push(9'h05A, 0, 0, 0);
    fork
      drive(8, nb, bits, 1, 0, -1, 14);
      begin
        repeat (30) @(negedge CLK);
        cfg(5, 6, 1, 1, 1);
      end
    join
    check_frame("post rst", s0 + 9 * 8 + 4 + 5);
    ack_chk("post rst", 9'h05A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
